// File: rtl/rpn_stack_regfile.sv
// LIFO register file serving the RPN control FSM: push/pop/replace-top with
// combinational top and top-1 reads, sticky error flags and a per-op ack.
module rpn_stack_regfile #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         err_clr,
  output logic [WIDTH-1:0]             stack_top,
  output logic [WIDTH-1:0]             stack_top_minus_one,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         ack
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt;
  logic             is_full;
  logic             is_empty;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    sec_idx;
  logic [AW-1:0]    nxt_idx;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;

  assign is_full  = (cnt == DEPTH_C);
  assign is_empty = (cnt == '0);

  // Index arithmetic may wrap when the stack is shallow; the read muxes hide it.
  assign top_idx = AW'(cnt - CW'(1));
  assign sec_idx = AW'(cnt - CW'(2));
  assign nxt_idx = AW'(cnt);

  assign stack_top           = is_empty ? '0 : mem[top_idx];
  assign stack_top_minus_one = (cnt >= CW'(2)) ? mem[sec_idx] : '0;

  assign full  = is_full;
  assign empty = is_empty;
  assign depth = cnt;

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = nxt_idx;
    if (push && pop && !is_empty) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push && (pop || !is_full)) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_idx] <= data_in;
    end
  end

  // A refusal later in this block overrides the err_clr clear of the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      ack       <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (err_clr) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      case ({push, pop})
        2'b10: begin
          if (!is_full) begin
            cnt <= cnt + CW'(1);
            ack <= 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
        2'b01: begin
          if (!is_empty) begin
            cnt <= cnt - CW'(1);
            ack <= 1'b1;
          end else begin
            underflow <= 1'b1;
          end
        end
        2'b11: begin
          if (is_empty) begin
            cnt <= CW'(1);
          end
          ack <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(is_full && is_empty));
  assert property (@(posedge clk) disable iff (rst) cnt <= DEPTH_C);

endmodule
